// File: rtl/block_sequencer.sv
// block_sequencer: nonce-search sequencer for a double-SHA-256 hashing core.
// Orders the compression passes, caches the chunk-1 midstate and walks the nonce range.
module block_sequencer #(
  parameter int ROUNDS = 64,
  parameter int RW     = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic [31:0]   nonce_first,
  input  logic [31:0]   nonce_last,
  input  logic          hit,
  output logic [1:0]    Block,
  output logic          nonce_sig,
  output logic [RW-1:0] round,
  output logic          round_en,
  output logic          load_w,
  output logic [31:0]   nonce,
  output logic          busy,
  output logic          done,
  output logic          found
);
  typedef enum logic [2:0] {IDLE, INIT, LOAD, RUN, STEP, CHECK, DONE} state_t;
  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);
  localparam logic [RW-1:0] ONE        = RW'(1);
  state_t        state_q, state_d;
  logic [1:0]    block_q, block_d, pass_q, pass_d;
  logic          sig_q, sig_d, done_q, done_d, found_q, found_d;
  logic [RW-1:0] round_q, round_d;
  logic [31:0]   nonce_q, nonce_d, last_q, last_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      block_q <= 2'd0;
      pass_q  <= 2'd0;
      sig_q   <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      round_q <= '0;
      nonce_q <= 32'd0;
      last_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      block_q <= block_d;
      pass_q  <= pass_d;
      sig_q   <= sig_d;
      done_q  <= done_d;
      found_q <= found_d;
      round_q <= round_d;
      nonce_q <= nonce_d;
      last_q  <= last_d;
    end
  end
  // pass_q holds the pass currently running; Block only moves on entry to INIT or STEP
  always_comb begin
    state_d = state_q;
    block_d = block_q;
    pass_d  = pass_q;
    sig_d   = sig_q;
    done_d  = 1'b0;
    found_d = found_q;
    round_d = round_q;
    nonce_d = nonce_q;
    last_d  = last_q;
    if (stop && state_q != IDLE) begin
      state_d = IDLE;
      block_d = 2'd0;
      sig_d   = 1'b0;
      done_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = INIT;
          block_d = 2'd0;
          sig_d   = 1'b0;
          found_d = 1'b0;
          nonce_d = nonce_first;
          last_d  = nonce_last;
        end
        INIT: begin
          state_d = LOAD;
          pass_d  = 2'd1;
        end
        LOAD: begin
          state_d = RUN;
          round_d = '0;
        end
        RUN: begin
          round_d = (round_q == LAST_ROUND) ? '0 : round_q + ONE;
          state_d = (round_q == LAST_ROUND) ? STEP : RUN;
          block_d = (round_q == LAST_ROUND) ? pass_q : block_q;
        end
        STEP: begin
          state_d = (pass_q == 2'd3) ? CHECK : LOAD;
          pass_d  = (pass_q == 2'd3) ? pass_q : pass_q + 2'd1;
        end
        CHECK: if (hit || nonce_q == last_q) begin
          state_d = DONE;
          found_d = hit;
          done_d  = 1'b1;
        end else begin
          state_d = LOAD;
          nonce_d = nonce_q + 32'd1;
          sig_d   = 1'b1;
          pass_d  = 2'd2;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  assign Block     = block_q;
  assign nonce_sig = sig_q;
  assign round     = round_q;
  assign round_en  = state_q == RUN;
  assign load_w    = state_q == LOAD;
  assign nonce     = nonce_q;
  assign busy      = state_q != IDLE && state_q != DONE;
  assign done      = done_q;
  assign found     = found_q;
endmodule

// File: tb/tb_block_sequencer.sv
// tb_block_sequencer: randomized and directed checks of block_sequencer against a
// cycle-schedule model derived from pass lengths and per-nonce latency.
module tb_block_sequencer;
  localparam int R = 64;
  localparam int L = R + 2;
  logic        clk = 1'b0;
  logic        rst_n, start, stop, hit;
  logic [31:0] nonce_first, nonce_last;
  logic [1:0]  Block;
  logic        nonce_sig, round_en, load_w, busy, done, found;
  logic [5:0]  round;
  logic [31:0] nonce;
  int          passed = 0;
  int          total = 0;

  typedef struct {
    logic [1:0]  blk;
    logic        sig, ren, lw, busy, done, found, chk;
    int          rnd, k;
    logic [31:0] nonce;
  } exp_t;

  block_sequencer #(.ROUNDS(R), .RW(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .nonce_first(nonce_first), .nonce_last(nonce_last), .hit(hit),
    .Block(Block), .nonce_sig(nonce_sig), .round(round), .round_en(round_en),
    .load_w(load_w), .nonce(nonce), .busy(busy), .done(done), .found(found)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " Block"}, Block, 0);
    chk({tag, " nonce_sig"}, nonce_sig, 0);
    chk({tag, " round"}, round, 0);
    chk({tag, " round_en"}, round_en, 0);
    chk({tag, " load_w"}, load_w, 0);
    chk({tag, " nonce"}, nonce, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " found"}, found, 0);
  endtask

  // Cycle c counts from the start cycle (c=0); INIT is c=1, then 3 passes of L cycles,
  // CHECK, and 2 passes plus CHECK for each later nonce; e is the index of the last nonce tested.
  function automatic exp_t model(input int c, input int e, input logic [31:0] first, input bit fnd);
    exp_t x;
    int t, r, k, p, o, cend;
    x.blk = 2'd0; x.sig = 0; x.ren = 0; x.lw = 0; x.busy = 1; x.done = 0;
    x.found = 0; x.chk = 0; x.rnd = -1; x.k = 0; x.nonce = first;
    cend = 2 + 3 * L + e * (2 * L + 1) + 1;
    if (c >= cend) begin
      x.blk = 2'd3; x.sig = (e > 0); x.busy = 0; x.done = (c == cend);
      x.found = fnd; x.nonce = first + 32'(e);
      return x;
    end
    if (c == 1) return x;
    t = c - 2;
    if (t < 3 * L + 1) begin
      k = 0; r = t;
    end else begin
      k = 1 + (t - (3 * L + 1)) / (2 * L + 1);
      r = (t - (3 * L + 1)) % (2 * L + 1);
    end
    x.k = k; x.sig = (k > 0); x.nonce = first + 32'(k);
    if ((k == 0 && r == 3 * L) || (k > 0 && r == 2 * L)) begin
      x.chk = 1; x.blk = 2'd3;
      return x;
    end
    p = (k == 0 ? 1 : 2) + r / L;
    o = r % L;
    x.lw = (o == 0);
    x.ren = (o >= 1 && o <= R);
    if (x.ren) x.rnd = o - 1;
    x.blk = (o == L - 1) ? 2'(p) : (p == 1 ? 2'd0 : (p == 2 ? (k == 0 ? 2'd1 : 2'd3) : 2'd2));
    return x;
  endfunction

  task automatic run(input logic [31:0] first, input logic [31:0] last, input int h,
                     input bit noise, input bit stop0);
    logic [32:0] n;
    int e, cend;
    bit fnd;
    exp_t x;
    n = {1'b0, last - first} + 33'd1;
    fnd = (h >= 0) && (33'(h) < n);
    e = fnd ? h : int'(n) - 1;
    cend = 2 + 3 * L + e * (2 * L + 1) + 1;
    for (int c = 0; c <= cend + 1; c++) begin
      @(negedge clk);
      if (c > 0) begin
        x = model(c, e, first, fnd);
        chk("Block", Block, x.blk);
        chk("nonce_sig", nonce_sig, x.sig);
        chk("round_en", round_en, x.ren);
        chk("load_w", load_w, x.lw);
        chk("busy", busy, x.busy);
        chk("done", done, x.done);
        chk("found", found, x.found);
        chk("nonce", nonce, x.nonce);
        if (x.rnd >= 0) chk("round", round, 32'(x.rnd));
        hit = x.chk ? (x.k == h) : 1'($urandom_range(0, 1));
      end else hit = 1'($urandom_range(0, 1));
      start = (c == 0) || (noise && c <= cend && $urandom_range(0, 15) == 0);
      stop = stop0 && c == 0;
      nonce_first = (c == 0 || !noise) ? first : $urandom;
      nonce_last = (c == 0 || !noise) ? last : $urandom;
    end
    start = 0; stop = 0; hit = 0;
  endtask

  task automatic begin_search(input logic [31:0] first, input logic [31:0] last);
    @(negedge clk);
    nonce_first = first; nonce_last = last; start = 1;
    @(negedge clk);
    start = 0;
  endtask

  initial begin
    logic [31:0] f;
    rst_n = 0; start = 0; stop = 0; hit = 0; nonce_first = 0; nonce_last = 0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1;
    run(32'd5, 32'd5, -1, 0, 1);
    run(32'd0, 32'd2, 2, 0, 0);
    run(32'hFFFF_FFFF, 32'd1, -1, 0, 0);
    run(32'hFFFF_FFFE, 32'd0, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      f = $urandom;
      run(f, f + 32'($urandom_range(0, 3)), $urandom_range(0, 5) - 1, 1, 0);
    end
    // stop at round 30 of pass 2 (c=99)
    begin_search(32'd10, 32'd20);
    repeat (98) @(negedge clk);
    chk("stop round", round, 30);
    chk("stop pre Block", Block, 1);
    stop = 1;
    @(negedge clk);
    stop = 0;
    chk("stop busy", busy, 0);
    chk("stop Block", Block, 0);
    chk("stop done", done, 1);
    chk("stop sig", nonce_sig, 0);
    chk("stop round_en", round_en, 0);
    @(negedge clk);
    chk("stop done end", done, 0);
    // stop and hit together in CHECK (c=200)
    begin_search(32'd7, 32'd7);
    repeat (199) @(negedge clk);
    chk("sh pre Block", Block, 3);
    stop = 1; hit = 1;
    @(negedge clk);
    stop = 0; hit = 0;
    chk("sh found", found, 0);
    chk("sh nonce", nonce, 7);
    chk("sh done", done, 1);
    chk("sh Block", Block, 0);
    chk("sh busy", busy, 0);
    // async reset at round 10 of pass 3 (c=145)
    begin_search(32'd3, 32'd9);
    repeat (144) @(negedge clk);
    chk("rst pre round", round, 10);
    chk("rst pre Block", Block, 2);
    #1 rst_n = 0;
    #1 chk_reset("async reset");
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post reset done", done, 0);
      chk("post reset busy", busy, 0);
    end
    @(negedge clk);
    nonce_first = 32'd1; nonce_last = 32'd1; start = 1;
    @(negedge clk);
    start = 0;
    chk("restart Block", Block, 0);
    chk("restart busy", busy, 1);
    chk("restart load_w", load_w, 0);
    @(negedge clk);
    chk("restart load_w2", load_w, 1);
    chk("restart Block2", Block, 0);
    stop = 1;
    @(negedge clk);
    stop = 0;
    chk("final busy", busy, 0);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
